if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch stage that sits directly downstream of the program counter. Drives the instruction-memory request with the current PC.
- Captures the returned instruction into the IF/ID pipeline register.
- Drives the PC's hold input, so the PC advances only when an instruction has been accepted.
- Handles decode stalls, branch flushes, and HLT detection.

Parameters:
- ADDR_W, 16, PC / instruction-memory address width.
- INSTR_W, 16, instruction width.
- HLT_OPCODE, 4'hF, value of instr[15:12] that identifies a halt instruction.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pc  in  ADDR_W  current PC from the program counter.
- pc_hold  out  1  to the PC's hold input; 1 = PC keeps its value.
- flush  in  1  branch taken this cycle; the PC loads its target on the same edge.
- imem_re  out  1  instruction-memory read request.
- imem_addr  out  ADDR_W  request address.
- imem_rdy  in  1  read data valid; completes the outstanding request.
- imem_data  in  INSTR_W  read data.
- id_stall  in  1  decode cannot accept a new instruction.
- id_valid  out  1  IF/ID register holds a valid instruction.
- id_instr  out  INSTR_W  IF/ID instruction.
- id_pc_plus1  out  ADDR_W  IF/ID fetched PC + 1 (wraps mod 2^ADDR_W).
- halted  out  1  HLT fetched; fetching stopped.

Behaviour:
- Reset values: state=IDLE, imem_re=0, pc_hold=1, id_valid=0, id_instr=0, id_pc_plus1=0, halted=0, hold buffer empty.
- Reset asserted mid-request abandons the request immediately; the memory must tolerate a dropped request.
- accept = ~id_valid | ~id_stall (the IF/ID slot is free or being drained).
- advance = (REQ & imem_rdy & accept & ~flush) | (HOLD & accept & ~flush).
- pc_hold = ~(advance | flush). A flush always lets the PC load its target.
- imem_addr = drop_addr in DROP, otherwise pc. imem_re=1 in REQ and DROP only.
- IF/ID register:
  - On advance: load the instruction and {fetched pc + 1}; id_valid=1.
  - Else if id_valid & ~id_stall: id_valid=0.
  - flush clears id_valid; flush has priority over id_stall and over advance.
- FSM states and transitions:
  - IDLE: -> REQ on the next cycle unconditionally.
  - REQ, imem_rdy & flush: discard the data -> REQ (the new PC is fetched the next cycle).
  - REQ, imem_rdy & accept: load IF/ID. If opcode==HLT_OPCODE -> HALT, else stay in REQ. Back-to-back fetch gives 1 instr/cycle for single-cycle memory.
  - REQ, imem_rdy & ~accept: latch {data, pc+1} into the hold buffer -> HOLD.
  - REQ, ~imem_rdy & flush: drop_addr<=pc -> DROP.
  - DROP: keep the request at drop_addr until imem_rdy, discard the data -> REQ. A further flush in DROP only reloads the PC.
  - HOLD: imem_re=0. On accept, move the buffer into IF/ID -> REQ (or HALT if the buffered instruction is HLT). On flush, discard the buffer -> REQ.
  - HALT: imem_re=0, pc_hold=1 (unless flush), halted=1. flush -> REQ and halted clears (squashes a speculatively fetched HLT). Otherwise remains until reset.
- Latency: fetch-to-ID = imem latency; IF/ID updates on the edge at which imem_rdy is sampled.
- Simultaneous flush and imem_rdy: the data is always discarded, never delivered.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- When defined:
  - Adds output perf_fetched[15:0], which counts advance cycles.
  - Adds output perf_stall[15:0], which counts cycles with state in {REQ, DROP, HOLD} & ~advance.
  - Both counters saturate at 16'hFFFF and reset to 0.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package wisc_pkg:
  - state enum {IDLE, REQ, DROP, HOLD, HALT}.
  - HLT_OPCODE constant.
  - ADDR_W and INSTR_W defaults.
- One natural sub-module: if_id_reg. It holds the IF/ID valid/instr/pc_plus1 register with load, drain and flush inputs, and is reused by later pipeline-register stages.

Test Plan:
- Single-cycle memory (rdy=1 every cycle), pc 0..3 returning 16'h1111..16'h4444 with no stalls -> id_instr updates every cycle, id_pc_plus1 = 1,2,3,4, pc_hold=0 each cycle.
- Memory with 3-cycle latency -> imem_re held for 3 cycles at a stable addr, pc_hold=1 for 2 cycles and 0 in the rdy cycle.
- id_stall=1 for 4 cycles while id_valid=1 and rdy arrives -> FSM enters HOLD, pc_hold=1. The buffered instruction enters IF/ID on the cycle after id_stall drops, with no loss or duplication.
- flush while a request at addr 5 is outstanding (rdy 2 cycles later) -> DROP keeps addr 5 until rdy, the data is discarded, id_valid=0, and the next request uses the branch target.
- Fetch 16'hF000 -> halted=1, imem_re=0, pc frozen. A later flush clears halted and resumes fetch at the target.
- flush and imem_rdy in the same cycle with id_stall=1 -> id_valid=0, the data is discarded, pc_hold=0.

Source files
------------

// File: rtl/wisc_pkg.sv
// Shared types and defaults for the WISC pipeline front end.
package wisc_pkg;

    localparam int unsigned ADDR_W_DEF     = 16;
    localparam int unsigned INSTR_W_DEF    = 16;
    localparam logic [3:0]  HLT_OPCODE_DEF = 4'hF;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        DROP = 3'd2,
        HOLD = 3'd3,
        HALT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register: valid/instr/pc_plus1 with flush > load > drain priority.
module if_id_reg #(
    parameter int unsigned ADDR_W  = wisc_pkg::ADDR_W_DEF,
    parameter int unsigned INSTR_W = wisc_pkg::INSTR_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_load,
    input  logic               i_drain,
    input  logic               i_flush,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [ADDR_W-1:0]  i_pc_plus1,
    output logic               o_valid,
    output logic [INSTR_W-1:0] o_instr,
    output logic [ADDR_W-1:0]  o_pc_plus1
);

    logic               r_valid;
    logic [INSTR_W-1:0] r_instr;
    logic [ADDR_W-1:0]  r_pc_plus1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_pc_plus1 <= '0;
        end else if (i_flush) begin
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_instr    <= i_instr;
            r_pc_plus1 <= i_pc_plus1;
        end else if (i_drain) begin
            r_valid    <= 1'b0;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_pc_plus1 = r_pc_plus1;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues imem reads at the PC, fills IF/ID, gates PC advance.
// Optional performance counters enabled by defining IFETCH_PERF_CNT_EN.
module if_fetch_unit #(
    parameter int unsigned ADDR_W     = wisc_pkg::ADDR_W_DEF,
    parameter int unsigned INSTR_W    = wisc_pkg::INSTR_W_DEF,
    parameter logic [3:0]  HLT_OPCODE = wisc_pkg::HLT_OPCODE_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  pc,
    output logic               pc_hold,
    input  logic               flush,
    output logic               imem_re,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_rdy,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               id_stall,
    output logic               id_valid,
    output logic [INSTR_W-1:0] id_instr,
    output logic [ADDR_W-1:0]  id_pc_plus1,
    output logic               halted
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_stall
`endif
);

    import wisc_pkg::*;

    fetch_state_e       r_state;
    logic [ADDR_W-1:0]  r_drop_addr;
    logic [ADDR_W-1:0]  r_buf_pc_plus1;
    logic [INSTR_W-1:0] r_buf_instr;

    logic               w_accept;
    logic               w_advance;
    logic               w_in_req;
    logic               w_in_hold;
    logic [ADDR_W-1:0]  w_pc_plus1;
    logic [INSTR_W-1:0] w_ld_instr;
    logic [ADDR_W-1:0]  w_ld_pc_plus1;
    logic               w_ld_hlt;

    assign w_in_req      = (r_state == REQ);
    assign w_in_hold     = (r_state == HOLD);
    assign w_accept      = ~id_valid | ~id_stall;
    assign w_advance     = ((w_in_req & imem_rdy) | w_in_hold) & w_accept & ~flush;
    assign w_pc_plus1    = pc + ADDR_W'(1);
    assign w_ld_instr    = w_in_hold ? r_buf_instr    : imem_data;
    assign w_ld_pc_plus1 = w_in_hold ? r_buf_pc_plus1 : w_pc_plus1;
    assign w_ld_hlt      = (w_ld_instr[INSTR_W-1 -: 4] == HLT_OPCODE);

    assign pc_hold   = ~(w_advance | flush);
    assign imem_re   = w_in_req | (r_state == DROP);
    assign imem_addr = (r_state == DROP) ? r_drop_addr : pc;
    assign halted    = (r_state == HALT);

    // Fetch sequencing; a flush squashes whatever the current request returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_drop_addr    <= '0;
            r_buf_instr    <= '0;
            r_buf_pc_plus1 <= '0;
        end else begin
            case (r_state)
                IDLE: r_state <= REQ;
                REQ: begin
                    if (imem_rdy) begin
                        if (flush) begin
                            r_state <= REQ;
                        end else if (w_accept) begin
                            r_state <= w_ld_hlt ? HALT : REQ;
                        end else begin
                            r_buf_instr    <= imem_data;
                            r_buf_pc_plus1 <= w_pc_plus1;
                            r_state        <= HOLD;
                        end
                    end else if (flush) begin
                        r_drop_addr <= pc;
                        r_state     <= DROP;
                    end
                end
                DROP: if (imem_rdy) r_state <= REQ;
                HOLD: begin
                    if (flush)         r_state <= REQ;
                    else if (w_accept) r_state <= w_ld_hlt ? HALT : REQ;
                end
                HALT: if (flush) r_state <= REQ;
                default: r_state <= IDLE;
            endcase
        end
    end

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_advance),
        .i_drain    (~id_stall),
        .i_flush    (flush),
        .i_instr    (w_ld_instr),
        .i_pc_plus1 (w_ld_pc_plus1),
        .o_valid    (id_valid),
        .o_instr    (id_instr),
        .o_pc_plus1 (id_pc_plus1)
    );

`ifdef IFETCH_PERF_CNT_EN
    logic [15:0] r_perf_fetched;
    logic [15:0] r_perf_stall;
    logic        w_busy;

    assign w_busy = w_in_req | w_in_hold | (r_state == DROP);

    // Saturating event counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetched <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_advance && (r_perf_fetched != 16'hFFFF))
                r_perf_fetched <= r_perf_fetched + 16'd1;
            if (w_busy && !w_advance && (r_perf_stall != 16'hFFFF))
                r_perf_stall <= r_perf_stall + 16'd1;
        end
    end

    assign perf_fetched = r_perf_fetched;
    assign perf_stall   = r_perf_stall;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit; the bench plays PC and instruction memory.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [15:0] pc;
    logic        pc_hold;
    logic        flush;
    logic        imem_re;
    logic [15:0] imem_addr;
    logic        imem_rdy;
    logic [15:0] imem_data;
    logic        id_stall;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] id_pc_plus1;
    logic        halted;

    int tests;
    int failed;

    if_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc          (pc),
        .pc_hold     (pc_hold),
        .flush       (flush),
        .imem_re     (imem_re),
        .imem_addr   (imem_addr),
        .imem_rdy    (imem_rdy),
        .imem_data   (imem_data),
        .id_stall    (id_stall),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc_plus1 (id_pc_plus1),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock: inputs change and outputs are sampled at the falling edge.
    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; pc = 16'h0; flush = 1'b0; imem_rdy = 1'b0;
        imem_data = 16'h0; id_stall = 1'b0;
        tick; tick;
        tests++; if (id_valid !== 1'b0) begin failed++; $display("FAIL rst_id_valid got %b exp 0", id_valid); end
        tests++; if (id_instr !== 16'h0) begin failed++; $display("FAIL rst_id_instr got %h exp 0000", id_instr); end
        tests++; if (id_pc_plus1 !== 16'h0) begin failed++; $display("FAIL rst_id_pc_plus1 got %h exp 0000", id_pc_plus1); end
        tests++; if (halted !== 1'b0) begin failed++; $display("FAIL rst_halted got %b exp 0", halted); end
        tests++; if (imem_re !== 1'b0) begin failed++; $display("FAIL rst_imem_re got %b exp 0", imem_re); end
        tests++; if (pc_hold !== 1'b1) begin failed++; $display("FAIL rst_pc_hold got %b exp 1", pc_hold); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_single_cycle;
        logic [15:0] exp_d;
        for (int i = 0; i < 4; i++) begin
            exp_d = 16'(16'h1111 * (i + 1));
            pc = 16'(i); imem_rdy = 1'b1; imem_data = exp_d;
            #1;
            tests++; if (pc_hold !== 1'b0) begin failed++; $display("FAIL sc_pc_hold i=%0d got %b exp 0", i, pc_hold); end
            tests++; if (imem_addr !== 16'(i)) begin failed++; $display("FAIL sc_addr i=%0d got %h exp %h", i, imem_addr, 16'(i)); end
            tick;
            tests++; if (id_instr !== exp_d || id_valid !== 1'b1) begin failed++; $display("FAIL sc_instr i=%0d got %h/%b exp %h/1", i, id_instr, id_valid, exp_d); end
            tests++; if (id_pc_plus1 !== 16'(i + 1)) begin failed++; $display("FAIL sc_pc_plus1 i=%0d got %h exp %h", i, id_pc_plus1, 16'(i + 1)); end
        end
        imem_rdy = 1'b0; pc = 16'd4;
        tick;
        tests++; if (id_valid !== 1'b0) begin failed++; $display("FAIL sc_drain got %b exp 0", id_valid); end
    endtask

    task automatic test_latency;
        pc = 16'd8; imem_rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) begin imem_rdy = 1'b1; imem_data = 16'h0ABC; end
            #1;
            tests++; if (imem_re !== 1'b1 || imem_addr !== 16'd8) begin failed++; $display("FAIL lat_req c=%0d got re=%b addr=%h exp re=1 addr=0008", c, imem_re, imem_addr); end
            tests++; if (pc_hold !== (c != 2)) begin failed++; $display("FAIL lat_pc_hold c=%0d got %b exp %b", c, pc_hold, (c != 2)); end
            tick;
        end
        tests++; if (id_instr !== 16'h0ABC || id_pc_plus1 !== 16'd9 || id_valid !== 1'b1) begin failed++; $display("FAIL lat_load got %h/%h/%b exp 0abc/0009/1", id_instr, id_pc_plus1, id_valid); end
    endtask

    task automatic test_hold_stall;
        pc = 16'd9; id_stall = 1'b1; imem_rdy = 1'b1; imem_data = 16'h2222;
        #1;
        tests++; if (pc_hold !== 1'b1) begin failed++; $display("FAIL hold_first_pc_hold got %b exp 1", pc_hold); end
        tick;
        imem_rdy = 1'b0; imem_data = 16'hBAD0;
        for (int c = 1; c < 4; c++) begin
            #1;
            tests++; if (imem_re !== 1'b0 || pc_hold !== 1'b1) begin failed++; $display("FAIL hold_wait c=%0d got re=%b hold=%b exp re=0 hold=1", c, imem_re, pc_hold); end
            tests++; if (id_instr !== 16'h0ABC || id_valid !== 1'b1) begin failed++; $display("FAIL hold_keep c=%0d got %h/%b exp 0abc/1", c, id_instr, id_valid); end
            tick;
        end
        id_stall = 1'b0;
        #1;
        tests++; if (pc_hold !== 1'b0) begin failed++; $display("FAIL hold_release_pc_hold got %b exp 0", pc_hold); end
        tick;
        tests++; if (id_instr !== 16'h2222 || id_pc_plus1 !== 16'd10 || id_valid !== 1'b1) begin failed++; $display("FAIL hold_deliver got %h/%h/%b exp 2222/000a/1", id_instr, id_pc_plus1, id_valid); end
        tests++; if (imem_re !== 1'b1) begin failed++; $display("FAIL hold_resume_re got %b exp 1", imem_re); end
        pc = 16'd10;
        tick;
        tests++; if (id_valid !== 1'b0) begin failed++; $display("FAIL hold_no_dup got %b exp 0", id_valid); end
    endtask

    task automatic test_flush_drop;
        pc = 16'd5; imem_rdy = 1'b0;
        #1;
        tests++; if (pc_hold !== 1'b1 || imem_addr !== 16'd5) begin failed++; $display("FAIL drop_pre got hold=%b addr=%h exp 1/0005", pc_hold, imem_addr); end
        tick;
        flush = 1'b1;
        #1;
        tests++; if (pc_hold !== 1'b0) begin failed++; $display("FAIL drop_flush_pc_hold got %b exp 0", pc_hold); end
        tick;
        flush = 1'b0; pc = 16'd20;
        for (int c = 0; c < 2; c++) begin
            if (c == 1) begin imem_rdy = 1'b1; imem_data = 16'h5555; end
            #1;
            tests++; if (imem_addr !== 16'd5 || imem_re !== 1'b1) begin failed++; $display("FAIL drop_addr c=%0d got %h/%b exp 0005/1", c, imem_addr, imem_re); end
            tests++; if (pc_hold !== 1'b1) begin failed++; $display("FAIL drop_pc_hold c=%0d got %b exp 1", c, pc_hold); end
            tick;
        end
        imem_rdy = 1'b0;
        #1;
        tests++; if (id_valid !== 1'b0) begin failed++; $display("FAIL drop_discard got %b exp 0", id_valid); end
        tests++; if (imem_addr !== 16'd20 || imem_re !== 1'b1) begin failed++; $display("FAIL drop_target got %h/%b exp 0014/1", imem_addr, imem_re); end
    endtask

    task automatic test_halt;
        pc = 16'd20; imem_rdy = 1'b1; imem_data = 16'hF000;
        #1;
        tests++; if (pc_hold !== 1'b0) begin failed++; $display("FAIL hlt_fetch_pc_hold got %b exp 0", pc_hold); end
        tick;
        imem_rdy = 1'b0; pc = 16'd21;
        for (int c = 0; c < 2; c++) begin
            #1;
            tests++; if (halted !== 1'b1 || imem_re !== 1'b0 || pc_hold !== 1'b1) begin failed++; $display("FAIL hlt_state c=%0d got halted=%b re=%b hold=%b exp 1/0/1", c, halted, imem_re, pc_hold); end
            tick;
        end
        tests++; if (id_instr !== 16'hF000 || id_pc_plus1 !== 16'd21) begin failed++; $display("FAIL hlt_ifid got %h/%h exp f000/0015", id_instr, id_pc_plus1); end
        flush = 1'b1;
        #1;
        tests++; if (pc_hold !== 1'b0) begin failed++; $display("FAIL hlt_flush_pc_hold got %b exp 0", pc_hold); end
        tick;
        flush = 1'b0; pc = 16'd30;
        #1;
        tests++; if (halted !== 1'b0 || imem_re !== 1'b1 || imem_addr !== 16'd30) begin failed++; $display("FAIL hlt_resume got halted=%b re=%b addr=%h exp 0/1/001e", halted, imem_re, imem_addr); end
    endtask

    task automatic test_flush_rdy_stall;
        pc = 16'd30; imem_rdy = 1'b1; imem_data = 16'h3030;
        tick;
        tests++; if (id_valid !== 1'b1 || id_pc_plus1 !== 16'd31) begin failed++; $display("FAIL frs_setup got %b/%h exp 1/001f", id_valid, id_pc_plus1); end
        pc = 16'd31; id_stall = 1'b1; flush = 1'b1; imem_data = 16'hDEAD;
        #1;
        tests++; if (pc_hold !== 1'b0) begin failed++; $display("FAIL frs_pc_hold got %b exp 0", pc_hold); end
        tick;
        flush = 1'b0; imem_rdy = 1'b0; id_stall = 1'b0; pc = 16'd40;
        #1;
        tests++; if (id_valid !== 1'b0) begin failed++; $display("FAIL frs_valid got %b exp 0", id_valid); end
        tests++; if (id_instr !== 16'h3030) begin failed++; $display("FAIL frs_discard got %h exp 3030", id_instr); end
        tests++; if (imem_re !== 1'b1 || imem_addr !== 16'd40) begin failed++; $display("FAIL frs_refetch got %b/%h exp 1/0028", imem_re, imem_addr); end
    endtask

    task automatic test_reset_abort;
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (imem_re !== 1'b0 || pc_hold !== 1'b1) begin failed++; $display("FAIL abort got re=%b hold=%b exp 0/1", imem_re, pc_hold); end
        tick;
        rst_n = 1'b1;
        tick;
    endtask

    initial begin
        tests = 0;
        failed = 0;
        test_reset;
        test_single_cycle;
        test_latency;
        test_hold_stall;
        test_flush_drop;
        test_halt;
        test_flush_rdy_stall;
        test_reset_abort;
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
